// File: rtl/pll_step_scheduler.sv
// Step scheduler feeding the three-phase PLL pipeline: collects phase samples,
// launches one computation per step, holds inputs, captures results, and flags faults.
// Ports: clk, rst (async low), rst_user (sync clear), enable, phase_valid/sel/data in;
// Va/Vb/Vc, sta out; pll_done, theta_in/sin_in/cos_in in; theta/sin/cos,
// result_valid, busy, stale, overrun_cnt, timeout_err out.
module pll_step_scheduler #(
  parameter int STEP_CYCLES    = 200,
  parameter int TIMEOUT_CYCLES = 160,
  parameter int W              = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rst_user,
  input  logic         enable,
  input  logic         phase_valid,
  input  logic [1:0]   phase_sel,
  input  logic [W-1:0] phase_data,
  output logic [W-1:0] Va,
  output logic [W-1:0] Vb,
  output logic [W-1:0] Vc,
  output logic         sta,
  input  logic         pll_done,
  input  logic [W-1:0] theta_in,
  input  logic [W-1:0] sin_in,
  input  logic [W-1:0] cos_in,
  output logic [W-1:0] theta,
  output logic [W-1:0] sin,
  output logic [W-1:0] cos,
  output logic         result_valid,
  output logic         busy,
  output logic         stale,
  output logic [15:0]  overrun_cnt,
  output logic         timeout_err
);

  localparam int TW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_DONE = 2'd1,
    CAPTURE   = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic [WW-1:0]  wait_q, wait_d;
  logic [W-1:0]   sha_q, sha_d, shb_q, shb_d, shc_q, shc_d;
  logic [2:0]     mask_q, mask_d;
  logic [W-1:0]   va_q, va_d, vb_q, vb_d, vc_q, vc_d;
  logic [W-1:0]   th_q, th_d, sn_q, sn_d, cs_q, cs_d;
  logic           sta_q, sta_d;
  logic           busy_q, busy_d;
  logic           stale_q, stale_d;
  logic           terr_q, terr_d;
  logic [15:0]    ovr_q, ovr_d, ovr_inc;
  logic [2:0]     wr;
  logic           tick;

  assign tick    = enable && (timer_q == TW'(STEP_CYCLES - 1));
  assign ovr_inc = ovr_q + {15'd0, ovr_q != 16'hFFFF};

  always_comb begin
    wr = 3'b000;
    if (phase_valid) begin
      unique case (1'b1)
        phase_sel == 2'd0: wr = 3'b001;
        phase_sel == 2'd1: wr = 3'b010;
        phase_sel == 2'd2: wr = 3'b100;
        default:           wr = 3'b000;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    wait_d  = wait_q;
    sha_d   = sha_q;
    shb_d   = shb_q;
    shc_d   = shc_q;
    mask_d  = mask_q | wr;
    va_d    = va_q;
    vb_d    = vb_q;
    vc_d    = vc_q;
    th_d    = th_q;
    sn_d    = sn_q;
    cs_d    = cs_q;
    sta_d   = 1'b0;
    busy_d  = busy_q;
    stale_d = stale_q;
    terr_d  = terr_q;
    ovr_d   = ovr_q;

    if (enable) timer_d = tick ? '0 : timer_q + TW'(1);
    if (wr[0]) sha_d = phase_data;
    if (wr[1]) shb_d = phase_data;
    if (wr[2]) shc_d = phase_data;

    unique case (state_q)
      IDLE: begin
        if (tick) begin
          // Snapshot takes pre-write shadows; a same-cycle write seeds the next step
          va_d    = sha_q;
          vb_d    = shb_q;
          vc_d    = shc_q;
          stale_d = (mask_q != 3'b111);
          mask_d  = wr;
          sta_d   = 1'b1;
          busy_d  = 1'b1;
          wait_d  = '0;
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        wait_d = wait_q + WW'(1);
        if (tick) ovr_d = ovr_inc;
        if (pll_done) begin
          th_d    = theta_in;
          sn_d    = sin_in;
          cs_d    = cos_in;
          state_d = CAPTURE;
        end else if (wait_q == WW'(TIMEOUT_CYCLES - 1)) begin
          terr_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      CAPTURE: begin
        if (tick) ovr_d = ovr_inc;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (rst_user) begin
      state_d = IDLE;
      timer_d = '0;
      wait_d  = '0;
      sha_d   = '0;
      shb_d   = '0;
      shc_d   = '0;
      mask_d  = '0;
      va_d    = '0;
      vb_d    = '0;
      vc_d    = '0;
      th_d    = '0;
      sn_d    = '0;
      cs_d    = '0;
      sta_d   = 1'b0;
      busy_d  = 1'b0;
      stale_d = 1'b0;
      terr_d  = 1'b0;
      ovr_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      timer_q <= '0;
      wait_q  <= '0;
      sha_q   <= '0;
      shb_q   <= '0;
      shc_q   <= '0;
      mask_q  <= '0;
      va_q    <= '0;
      vb_q    <= '0;
      vc_q    <= '0;
      th_q    <= '0;
      sn_q    <= '0;
      cs_q    <= '0;
      sta_q   <= 1'b0;
      busy_q  <= 1'b0;
      stale_q <= 1'b0;
      terr_q  <= 1'b0;
      ovr_q   <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      wait_q  <= wait_d;
      sha_q   <= sha_d;
      shb_q   <= shb_d;
      shc_q   <= shc_d;
      mask_q  <= mask_d;
      va_q    <= va_d;
      vb_q    <= vb_d;
      vc_q    <= vc_d;
      th_q    <= th_d;
      sn_q    <= sn_d;
      cs_q    <= cs_d;
      sta_q   <= sta_d;
      busy_q  <= busy_d;
      stale_q <= stale_d;
      terr_q  <= terr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign Va           = va_q;
  assign Vb           = vb_q;
  assign Vc           = vc_q;
  assign sta          = sta_q;
  assign theta        = th_q;
  assign sin          = sn_q;
  assign cos          = cs_q;
  assign result_valid = (state_q == CAPTURE);
  assign busy         = busy_q;
  assign stale        = stale_q;
  assign overrun_cnt  = ovr_q;
  assign timeout_err  = terr_q;

endmodule

// File: tb/tb_pll_step_scheduler.sv
// Directed bench for pll_step_scheduler: nominal, stale, timeout,
// collision, reset, overrun and saturation across three parameterisations.
module tb_pll_step_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rst_user = 1'b0;
  logic        en_a = 1'b0, en_b = 1'b0, en_c = 1'b0;
  logic        pv = 1'b0;
  logic [1:0]  sel = 2'd0;
  logic [31:0] data = '0;
  logic        done = 1'b0;
  logic [31:0] th_in = '0, sn_in = '0, cs_in = '0;

  logic [31:0] va_a, vb_a, vc_a, th_a, sn_a, cs_a;
  logic        sta_a, rv_a, busy_a, stale_a, terr_a;
  logic [15:0] ovr_a;
  logic [31:0] va_b, vb_b, vc_b, th_b, sn_b, cs_b;
  logic        sta_b, rv_b, busy_b, stale_b, terr_b;
  logic [15:0] ovr_b;
  logic [31:0] va_c, vb_c, vc_c, th_c, sn_c, cs_c;
  logic        sta_c, rv_c, busy_c, stale_c, terr_c;
  logic [15:0] ovr_c;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int t0, nb, nc;

  always #5 clk = ~clk;

  pll_step_scheduler #(.STEP_CYCLES(200), .TIMEOUT_CYCLES(160), .W(32)) u_a (
    .clk(clk), .rst(rst), .rst_user(rst_user), .enable(en_a),
    .phase_valid(pv), .phase_sel(sel), .phase_data(data),
    .Va(va_a), .Vb(vb_a), .Vc(vc_a), .sta(sta_a), .pll_done(done),
    .theta_in(th_in), .sin_in(sn_in), .cos_in(cs_in),
    .theta(th_a), .sin(sn_a), .cos(cs_a), .result_valid(rv_a),
    .busy(busy_a), .stale(stale_a), .overrun_cnt(ovr_a),
    .timeout_err(terr_a)
  );

  pll_step_scheduler #(.STEP_CYCLES(100), .TIMEOUT_CYCLES(160), .W(32)) u_b (
    .clk(clk), .rst(rst), .rst_user(rst_user), .enable(en_b),
    .phase_valid(pv), .phase_sel(sel), .phase_data(data),
    .Va(va_b), .Vb(vb_b), .Vc(vc_b), .sta(sta_b), .pll_done(done),
    .theta_in(th_in), .sin_in(sn_in), .cos_in(cs_in),
    .theta(th_b), .sin(sn_b), .cos(cs_b), .result_valid(rv_b),
    .busy(busy_b), .stale(stale_b), .overrun_cnt(ovr_b),
    .timeout_err(terr_b)
  );

  pll_step_scheduler #(.STEP_CYCLES(1), .TIMEOUT_CYCLES(100000), .W(32)) u_c (
    .clk(clk), .rst(rst), .rst_user(rst_user), .enable(en_c),
    .phase_valid(pv), .phase_sel(sel), .phase_data(data),
    .Va(va_c), .Vb(vb_c), .Vc(vc_c), .sta(sta_c), .pll_done(done),
    .theta_in(th_in), .sin_in(sn_in), .cos_in(cs_in),
    .theta(th_c), .sin(sn_c), .cos(cs_c), .result_valid(rv_c),
    .busy(busy_c), .stale(stale_c), .overrun_cnt(ovr_c),
    .timeout_err(terr_c)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %08h want %08h", tag, cyc, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic to(input int n);
    if (n > cyc) step(n - cyc);
  endtask

  task automatic put(input logic [1:0] s, input logic [31:0] d);
    pv   = 1'b1;
    sel  = s;
    data = d;
    step(1);
    pv   = 1'b0;
  endtask

  initial begin
    step(2);
    chk("rst_sta", 32'(sta_a), 32'd0);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_va", va_a, 32'h0);
    chk("rst_ovr", 32'(ovr_a), 32'd0);
    rst  = 1'b1;
    en_a = 1'b1;
    t0   = cyc;

    // nominal launch
    put(2'd0, 32'h3F800000);
    put(2'd1, 32'hBF000000);
    put(2'd2, 32'hBF000000);
    to(t0 + 199);
    chk("nom_presta", 32'(sta_a), 32'd0);
    to(t0 + 200);
    chk("nom_sta", 32'(sta_a), 32'd1);
    chk("nom_va", va_a, 32'h3F800000);
    chk("nom_vb", vb_a, 32'hBF000000);
    chk("nom_vc", vc_a, 32'hBF000000);
    chk("nom_busy", 32'(busy_a), 32'd1);
    chk("nom_stale", 32'(stale_a), 32'd0);
    step(1);
    chk("nom_sta_w", 32'(sta_a), 32'd0);
    to(t0 + 328);
    done  = 1'b1;
    th_in = 32'h3F000000;
    sn_in = 32'h3F5DB3D7;
    cs_in = 32'h3F000000;
    chk("nom_hold", va_a, 32'h3F800000);
    step(1);
    done = 1'b0;
    chk("nom_rv", 32'(rv_a), 32'd1);
    chk("nom_theta", th_a, 32'h3F000000);
    chk("nom_sin", sn_a, 32'h3F5DB3D7);
    step(1);
    chk("nom_rv_w", 32'(rv_a), 32'd0);
    chk("nom_busy_clr", 32'(busy_a), 32'd0);

    // stale launch: only Va refreshed
    put(2'd0, 32'h40000000);
    to(t0 + 400);
    chk("stl_sta", 32'(sta_a), 32'd1);
    chk("stl_stale", 32'(stale_a), 32'd1);
    chk("stl_va", va_a, 32'h40000000);
    chk("stl_vb", vb_a, 32'hBF000000);
    put(2'd0, 32'h40400000);
    put(2'd1, 32'hC0000000);
    put(2'd2, 32'h3E800000);
    to(t0 + 528);
    done  = 1'b1;
    th_in = 32'h3E000000;
    step(1);
    done = 1'b0;
    chk("stl_theta", th_a, 32'h3E000000);
    to(t0 + 600);
    chk("full_sta", 32'(sta_a), 32'd1);
    chk("full_stale", 32'(stale_a), 32'd0);
    chk("full_va", va_a, 32'h40400000);
    chk("full_vc", vc_a, 32'h3E800000);

    // timeout
    to(t0 + 759);
    chk("to_pre", 32'(terr_a), 32'd0);
    chk("to_busy_pre", 32'(busy_a), 32'd1);
    to(t0 + 760);
    chk("to_err", 32'(terr_a), 32'd1);
    chk("to_busy", 32'(busy_a), 32'd0);
    to(t0 + 800);
    chk("to_relaunch", 32'(sta_a), 32'd1);
    chk("to_sticky", 32'(terr_a), 32'd1);
    chk("to_stale", 32'(stale_a), 32'd1);

    // collision on tick cycle
    to(t0 + 961);
    put(2'd0, 32'h11111111);
    put(2'd1, 32'h22222222);
    put(2'd2, 32'h33333333);
    to(t0 + 999);
    put(2'd0, 32'h44444444);
    chk("col_sta", 32'(sta_a), 32'd1);
    chk("col_va_old", va_a, 32'h11111111);
    chk("col_stale", 32'(stale_a), 32'd0);

    // spurious done in IDLE
    to(t0 + 1170);
    done  = 1'b1;
    th_in = 32'hDEADBEEF;
    step(1);
    done = 1'b0;
    chk("spur_rv", 32'(rv_a), 32'd0);
    chk("spur_theta", th_a, 32'h3E000000);
    chk("spur_busy", 32'(busy_a), 32'd0);
    to(t0 + 1200);
    chk("col_sta2", 32'(sta_a), 32'd1);
    chk("col_va_new", va_a, 32'h44444444);
    chk("col_vb", vb_a, 32'h22222222);
    chk("col_stale2", 32'(stale_a), 32'd1);

    // synchronous user clear
    to(t0 + 1205);
    rst_user = 1'b1;
    step(1);
    rst_user = 1'b0;
    chk("usr_terr", 32'(terr_a), 32'd0);
    chk("usr_busy", 32'(busy_a), 32'd0);
    chk("usr_va", va_a, 32'h0);
    chk("usr_theta", th_a, 32'h0);
    put(2'd0, 32'h55555555);
    to(t0 + 1405);
    chk("usr_presta", 32'(sta_a), 32'd0);
    to(t0 + 1406);
    chk("usr_sta", 32'(sta_a), 32'd1);
    chk("usr_va2", va_a, 32'h55555555);
    chk("usr_stale", 32'(stale_a), 32'd1);

    // async reset mid WAIT_DONE
    to(t0 + 1410);
    rst = 1'b0;
    #1;
    chk("ar_busy", 32'(busy_a), 32'd0);
    chk("ar_va", va_a, 32'h0);
    chk("ar_stale", 32'(stale_a), 32'd0);
    step(1);
    rst = 1'b1;
    to(t0 + 1610);
    chk("ar_presta", 32'(sta_a), 32'd0);
    to(t0 + 1611);
    chk("ar_sta", 32'(sta_a), 32'd1);
    en_a = 1'b0;

    // overrun with 100-cycle step
    nb   = cyc;
    en_b = 1'b1;
    to(nb + 100);
    chk("ov_sta", 32'(sta_b), 32'd1);
    to(nb + 199);
    chk("ov_pre", 32'(ovr_b), 32'd0);
    to(nb + 200);
    chk("ov_cnt1", 32'(ovr_b), 32'd1);
    chk("ov_nosta", 32'(sta_b), 32'd0);
    chk("ov_busy", 32'(busy_b), 32'd1);
    to(nb + 230);
    done  = 1'b1;
    th_in = 32'h12345678;
    step(1);
    done = 1'b0;
    chk("ov_rv", 32'(rv_b), 32'd1);
    chk("ov_theta", th_b, 32'h12345678);
    to(nb + 300);
    chk("ov_sta2", 32'(sta_b), 32'd1);
    to(nb + 399);
    done  = 1'b1;
    th_in = 32'h87654321;
    step(1);
    done = 1'b0;
    chk("ovd_cnt2", 32'(ovr_b), 32'd2);
    chk("ovd_rv", 32'(rv_b), 32'd1);
    chk("ovd_theta", th_b, 32'h87654321);
    en_b = 1'b0;

    // saturation: tick every cycle while stuck waiting
    nc   = cyc;
    en_c = 1'b1;
    to(nc + 1);
    chk("sat_sta", 32'(sta_c), 32'd1);
    to(nc + 2);
    chk("sat_cnt1", 32'(ovr_c), 32'd1);
    to(nc + 65535);
    chk("sat_fffe", 32'(ovr_c), 32'h0000FFFE);
    to(nc + 65536);
    chk("sat_ffff", 32'(ovr_c), 32'h0000FFFF);
    to(nc + 65546);
    chk("sat_hold", 32'(ovr_c), 32'h0000FFFF);
    en_c = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
